// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the program counter it drives.
package fetch_unit_pkg;

    // Width of the PC select code shared with the PC block.
    localparam int unsigned OPT_SIZE = 2;

    // PC select codes; the PC decodes these directly.
    typedef enum logic [OPT_SIZE-1:0] {
        NEXT_INSTR = 2'd0,
        KEEP_INSTR = 2'd1,
        LOAD_INSTR = 2'd2
    } pc_sel_e;

    // Fetch FSM state encoding.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2,
        StDrain = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads the PC, issues a req/ack read to instruction
// memory and hands the fetched word to decode over valid/ready. Steers the PC
// with NEXT on capture, LOAD on redirect and KEEP otherwise.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic [WORD_SIZE-1:0] pc_addr_i,
    output logic [OPT_SIZE-1:0]  pc_sel_o,
    output logic [WORD_SIZE-1:0] pc_load_o,
    input  logic                 redirect_valid_i,
    input  logic [WORD_SIZE-1:0] redirect_target_i,
    output logic                 mem_req_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    input  logic                 mem_ack_i,
    input  logic [WORD_SIZE-1:0] mem_rdata_i,
    output logic                 ir_valid_o,
    input  logic                 ir_ready_i,
    output logic [WORD_SIZE-1:0] ir_data_o,
    output logic [WORD_SIZE-1:0] ir_pc_o
);

    fetch_state_e         state_q;
    logic                 mem_req_q;
    logic [ADDR_SIZE-1:0] mem_addr_q;
    logic                 ir_valid_q;
    logic [WORD_SIZE-1:0] ir_data_q;
    logic [WORD_SIZE-1:0] ir_pc_q;

    // PC steering: redirect beats a capture; NEXT only when a word is accepted.
    always_comb begin
        pc_sel_o  = KEEP_INSTR;
        pc_load_o = '0;
        if (!rst) begin
            pc_load_o = redirect_target_i;
            if (redirect_valid_i) begin
                pc_sel_o = LOAD_INSTR;
            end else if (state_q == StFetch && mem_ack_i) begin
                pc_sel_o = NEXT_INSTR;
            end
        end
    end

    // Fetch FSM with registered memory and decode-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            ir_valid_q <= 1'b0;
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // On redirect the PC is loading this cycle; fetch from it next cycle.
                    if (!redirect_valid_i && enable_i) begin
                        mem_addr_q <= pc_addr_i[ADDR_SIZE-1:0];
                        ir_pc_q    <= pc_addr_i;
                        mem_req_q  <= 1'b1;
                        state_q    <= StFetch;
                    end
                end
                StFetch: begin
                    if (redirect_valid_i) begin
                        if (mem_ack_i) begin
                            mem_req_q <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            // Request cannot be withdrawn; wait out its ack.
                            state_q <= StDrain;
                        end
                    end else if (mem_ack_i) begin
                        ir_data_q  <= mem_rdata_i;
                        mem_req_q  <= 1'b0;
                        ir_valid_q <= 1'b1;
                        state_q    <= StHold;
                    end
                end
                StHold: begin
                    if (redirect_valid_i) begin
                        // Cancels the held instruction even if decode accepts now.
                        ir_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end else if (ir_ready_i) begin
                        ir_valid_q <= 1'b0;
                        if (enable_i) begin
                            // PC already advanced on the NEXT issued at capture.
                            mem_addr_q <= pc_addr_i[ADDR_SIZE-1:0];
                            ir_pc_q    <= pc_addr_i;
                            mem_req_q  <= 1'b1;
                            state_q    <= StFetch;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StDrain: begin
                    // The ack closes the abandoned request even alongside a new
                    // redirect; that redirect still issues LOAD combinationally.
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    mem_req_q  <= 1'b0;
                    ir_valid_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign ir_valid_o = ir_valid_q;
    assign ir_data_o  = ir_data_q;
    assign ir_pc_o    = ir_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] pc_addr;
    logic [1:0]  pc_sel;
    logic [31:0] pc_load;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        mem_req;
    logic [13:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_data;
    logic [31:0] ir_pc;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] SelNext = 32'd0;
    localparam logic [31:0] SelKeep = 32'd1;
    localparam logic [31:0] SelLoad = 32'd2;

    fetch_unit #(
        .WORD_SIZE(32),
        .ADDR_SIZE(14)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .enable_i          (enable),
        .pc_addr_i         (pc_addr),
        .pc_sel_o          (pc_sel),
        .pc_load_o         (pc_load),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .mem_req_o         (mem_req),
        .mem_addr_o        (mem_addr),
        .mem_ack_i         (mem_ack),
        .mem_rdata_i       (mem_rdata),
        .ir_valid_o        (ir_valid),
        .ir_ready_i        (ir_ready),
        .ir_data_o         (ir_data),
        .ir_pc_o           (ir_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        enable          = 1'b0;
        pc_addr         = 32'h0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h123;
        mem_ack         = 1'b0;
        mem_rdata       = 32'h0;
        ir_ready        = 1'b0;
        step();
        step();
        check("rst_pc_sel", {30'd0, pc_sel}, SelKeep);
        check("rst_pc_load", pc_load, 32'h0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("rst_mem_addr", {18'd0, mem_addr}, 32'd0);

        // First fetch from PC 0 with one-cycle memory latency.
        rst    = 1'b0;
        enable = 1'b1;
        #1;
        check("pc_load_follows_target", pc_load, 32'h123);
        step();
        check("f0_mem_req", {31'd0, mem_req}, 32'd1);
        check("f0_mem_addr", {18'd0, mem_addr}, 32'd0);
        check("f0_pc_sel_wait", {30'd0, pc_sel}, SelKeep);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        #1;
        check("f0_pc_sel_next", {30'd0, pc_sel}, SelNext);
        step();
        mem_ack = 1'b0;
        pc_addr = 32'h1;
        #1;
        check("f0_ir_valid", {31'd0, ir_valid}, 32'd1);
        check("f0_ir_data", ir_data, 32'hDEADBEEF);
        check("f0_ir_pc", ir_pc, 32'h0);
        check("f0_req_dropped", {31'd0, mem_req}, 32'd0);
        check("f0_next_one_cycle", {30'd0, pc_sel}, SelKeep);

        // Decode stalls for five cycles; the held instruction must not move.
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", {31'd0, ir_valid}, 32'd1);
            check("hold_data", ir_data, 32'hDEADBEEF);
            check("hold_pc", ir_pc, 32'h0);
            check("hold_req", {31'd0, mem_req}, 32'd0);
            check("hold_sel", {30'd0, pc_sel}, SelKeep);
        end
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        check("f1_ir_valid_cleared", {31'd0, ir_valid}, 32'd0);
        check("f1_mem_req", {31'd0, mem_req}, 32'd1);
        check("f1_mem_addr", {18'd0, mem_addr}, 32'd1);
        check("f1_ir_pc", ir_pc, 32'h1);

        // Redirect during FETCH; memory answers three cycles later.
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        #1;
        check("rd_fetch_sel", {30'd0, pc_sel}, SelLoad);
        check("rd_fetch_load", pc_load, 32'h40);
        step();
        redirect_valid = 1'b0;
        pc_addr        = 32'h40;
        check("drain_req_held", {31'd0, mem_req}, 32'd1);
        check("drain_addr_held", {18'd0, mem_addr}, 32'd1);
        step();
        step();
        check("drain_no_valid", {31'd0, ir_valid}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h00000BAD;
        #1;
        check("drain_ack_no_next", {30'd0, pc_sel}, SelKeep);
        step();
        mem_ack = 1'b0;
        check("drain_done_req", {31'd0, mem_req}, 32'd0);
        check("drain_done_valid", {31'd0, ir_valid}, 32'd0);
        step();
        check("rd_target_req", {31'd0, mem_req}, 32'd1);
        check("rd_target_addr", {18'd0, mem_addr}, 32'h40);

        // Redirect coinciding with mem_ack: no NEXT, data dropped.
        mem_ack         = 1'b1;
        mem_rdata       = 32'hCAFEF00D;
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        #1;
        check("rd_ack_sel", {30'd0, pc_sel}, SelLoad);
        step();
        mem_ack        = 1'b0;
        redirect_valid = 1'b0;
        pc_addr        = 32'h80;
        check("rd_ack_req", {31'd0, mem_req}, 32'd0);
        check("rd_ack_valid", {31'd0, ir_valid}, 32'd0);
        step();
        check("rd_ack_refetch", {18'd0, mem_addr}, 32'h80);
        check("rd_ack_refetch_req", {31'd0, mem_req}, 32'd1);

        // Capture, then redirect together with ir_ready in HOLD.
        mem_ack   = 1'b1;
        mem_rdata = 32'h11111111;
        step();
        mem_ack = 1'b0;
        pc_addr = 32'h81;
        check("h2_valid", {31'd0, ir_valid}, 32'd1);
        check("h2_pc", ir_pc, 32'h80);
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        ir_ready        = 1'b1;
        #1;
        check("rd_hold_sel", {30'd0, pc_sel}, SelLoad);
        step();
        redirect_valid = 1'b0;
        ir_ready       = 1'b0;
        pc_addr        = 32'h100;
        check("rd_hold_valid", {31'd0, ir_valid}, 32'd0);
        check("rd_hold_req", {31'd0, mem_req}, 32'd0);
        step();
        check("rd_hold_refetch", {18'd0, mem_addr}, 32'h100);
        check("rd_hold_refetch_pc", ir_pc, 32'h100);

        // Accept with enable low, then address truncation from IDLE.
        mem_ack   = 1'b1;
        mem_rdata = 32'h22222222;
        step();
        mem_ack  = 1'b0;
        enable   = 1'b0;
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        check("dis_valid", {31'd0, ir_valid}, 32'd0);
        check("dis_req", {31'd0, mem_req}, 32'd0);
        pc_addr = 32'h4005;
        step();
        check("dis_idle_req", {31'd0, mem_req}, 32'd0);
        enable = 1'b1;
        step();
        check("trunc_addr", {18'd0, mem_addr}, 32'h5);
        check("trunc_ir_pc", ir_pc, 32'h4005);
        check("trunc_req", {31'd0, mem_req}, 32'd1);

        // Reset in the middle of a fetch.
        rst = 1'b1;
        #1;
        check("midrst_sel", {30'd0, pc_sel}, SelKeep);
        check("midrst_load", pc_load, 32'h0);
        step();
        check("midrst_req", {31'd0, mem_req}, 32'd0);
        check("midrst_valid", {31'd0, ir_valid}, 32'd0);
        check("midrst_addr", {18'd0, mem_addr}, 32'd0);
        check("midrst_ir_pc", ir_pc, 32'd0);
        rst    = 1'b0;
        enable = 1'b0;
        step();
        check("post_rst_idle", {31'd0, mem_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
